// File: rtl/seven_segment_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_capture_pkg
// Description : Shared definitions for the seven-segment capture path. Holds
//               the active-low abcdefg glyphs (bit 6 = a), which the display
//               driver's digit encoder uses too, the blank pattern, and the
//               capture FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_segment_capture_pkg;

  // Active-low glyphs, bit 6 = segment a ... bit 0 = segment g
  localparam logic [6:0] c_glyph_0 = 7'b0000001;
  localparam logic [6:0] c_glyph_1 = 7'b1001111;
  localparam logic [6:0] c_glyph_2 = 7'b0010010;
  localparam logic [6:0] c_glyph_3 = 7'b0000110;
  localparam logic [6:0] c_glyph_4 = 7'b1001100;
  localparam logic [6:0] c_glyph_5 = 7'b0100100;
  localparam logic [6:0] c_glyph_6 = 7'b0100000;
  localparam logic [6:0] c_glyph_7 = 7'b0001111;
  localparam logic [6:0] c_glyph_8 = 7'b0000000;
  localparam logic [6:0] c_glyph_9 = 7'b0000100;
  localparam logic [6:0] c_glyph_a = 7'b0001000;
  localparam logic [6:0] c_glyph_b = 7'b1100000;
  localparam logic [6:0] c_glyph_c = 7'b0110001;
  localparam logic [6:0] c_glyph_d = 7'b1000010;
  localparam logic [6:0] c_glyph_e = 7'b0110000;
  localparam logic [6:0] c_glyph_f = 7'b0111000;

  // All segments off
  localparam logic [6:0] c_blank = 7'h7F;

  // Capture FSM: wait for the anodes to settle, then hold until they move
  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_HOLD   = 1'b1
  } state_t;

endpackage : seven_segment_capture_pkg
`default_nettype wire

// File: rtl/seven_segment_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_glyph_decode
// Description : Combinational reverse glyph lookup. Maps an active-low
//               abcdefg pattern back to its hex nibble; anything that is not
//               one of the 16 hex glyphs (blank included) raises illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_glyph_decode
  import seven_segment_capture_pkg::*;
(
  input  logic [6:0] abcdefg,
  output logic [3:0] nibble,
  output logic       illegal
);

  // Exact-match lookup against the shared glyph table
  always_comb begin
    nibble  = 4'h0;
    illegal = 1'b0;
    case (abcdefg)
      c_glyph_0: nibble = 4'h0;
      c_glyph_1: nibble = 4'h1;
      c_glyph_2: nibble = 4'h2;
      c_glyph_3: nibble = 4'h3;
      c_glyph_4: nibble = 4'h4;
      c_glyph_5: nibble = 4'h5;
      c_glyph_6: nibble = 4'h6;
      c_glyph_7: nibble = 4'h7;
      c_glyph_8: nibble = 4'h8;
      c_glyph_9: nibble = 4'h9;
      c_glyph_a: nibble = 4'hA;
      c_glyph_b: nibble = 4'hB;
      c_glyph_c: nibble = 4'hC;
      c_glyph_d: nibble = 4'hD;
      c_glyph_e: nibble = 4'hE;
      c_glyph_f: nibble = 4'hF;
      default:   illegal = 1'b1;
    endcase
  end

endmodule : seven_segment_glyph_decode
`default_nettype wire

// File: rtl/seven_segment_capture.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_capture
// Description : Receive side of a multiplexed seven-segment display. Watches
//               the scanned anodes, abcdefg and dot lines, waits for each
//               anode selection to settle, decodes the selected digit and
//               reassembles the full number and dot vector. A frame is
//               published (valid pulse) once every digit slot has been
//               captured.
//               Optional watchdog: define SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN to
//               raise stale when no legal sample arrives for TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_capture
  import seven_segment_capture_pkg::*;
#(
  parameter int W              = 32,
  parameter int BITS_PER_DIGIT = 4,
  parameter int N_DIGITS       = W / BITS_PER_DIGIT,
`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 65536,
`endif
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_DIGITS-1:0] anodes,
  input  logic [6:0]          abcdefg,
  input  logic                dot,
  output logic [W-1:0]        num,
  output logic [N_DIGITS-1:0] dots,
  output logic                valid,
  output logic                seg_err,
  output logic                stale
);

  localparam int                 c_cnt_w    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE_CYCLES - 1);

  // Synchroniser stages (idle / inactive = all ones)
  logic [N_DIGITS-1:0] anodes_meta_q, anodes_sync_q, anodes_prev_q;
  logic [6:0]          seg_meta_q, seg_sync_q;
  logic                dot_meta_q, dot_sync_q;

  // FSM
  state_t              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;

  // Frame assembly and outputs
  logic [N_DIGITS-1:0] captured_q, captured_d;
  logic [W-1:0]        shadow_num_q, shadow_num_d;
  logic [N_DIGITS-1:0] shadow_dots_q, shadow_dots_d;
  logic                frame_pending_q, frame_pending_d;
  logic [W-1:0]        num_q, num_d;
  logic [N_DIGITS-1:0] dots_q, dots_d;
  logic                valid_q, valid_d;
  logic                seg_err_q, seg_err_d;

  logic                w_change;
  logic                w_sample;
  logic [N_DIGITS-1:0] w_sel;
  logic                w_onehot;
  logic [3:0]          w_nibble;
  logic                w_illegal;
  logic                w_legal_sample;

  seven_segment_glyph_decode u_decode (
    .abcdefg (seg_sync_q),
    .nibble  (w_nibble),
    .illegal (w_illegal)
  );

  assign w_change       = (anodes_sync_q != anodes_prev_q);
  assign w_sel          = ~anodes_sync_q;
  assign w_onehot       = (w_sel != '0) && ((w_sel & (w_sel - 1'b1)) == '0);
  assign w_legal_sample = w_sample && w_onehot && !w_illegal;

  // Two-flop synchronisers plus the previous-anodes copy for change detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anodes_meta_q <= '1;
      anodes_sync_q <= '1;
      anodes_prev_q <= '1;
      seg_meta_q    <= '1;
      seg_sync_q    <= '1;
      dot_meta_q    <= 1'b1;
      dot_sync_q    <= 1'b1;
    end else begin
      anodes_meta_q <= anodes;
      anodes_sync_q <= anodes_meta_q;
      anodes_prev_q <= anodes_sync_q;
      seg_meta_q    <= abcdefg;
      seg_sync_q    <= seg_meta_q;
      dot_meta_q    <= dot;
      dot_sync_q    <= dot_meta_q;
    end
  end

  // FSM state and settle counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: count stable cycles, sample once, hold until anodes move
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_sample = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if (w_change) begin
          cnt_d = '0;                 // a change always beats a pending sample
        end else if (cnt_q == c_cnt_last) begin
          w_sample = 1'b1;
          state_d  = ST_HOLD;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_change) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
  localparam int                c_wd_w   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(TIMEOUT_CYCLES);

  logic [c_wd_w-1:0] wd_q, wd_d;

  // Watchdog counter: cycles since the last legal sample, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign stale = (wd_q == c_wd_max);
`else
  assign stale = 1'b0;
`endif

  // Datapath: frame commit, per-slot shadow update, error pulse, watchdog
  always_comb begin
    captured_d      = captured_q;
    shadow_num_d    = shadow_num_q;
    shadow_dots_d   = shadow_dots_q;
    frame_pending_d = 1'b0;
    num_d           = num_q;
    dots_d          = dots_q;
    valid_d         = 1'b0;
    seg_err_d       = 1'b0;

    // Publish the frame completed by the previous cycle's sample
    if (frame_pending_q) begin
      num_d      = shadow_num_q;
      dots_d     = shadow_dots_q;
      valid_d    = 1'b1;
      captured_d = '0;
    end

`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
    wd_d = wd_q;
    if (w_legal_sample) begin
      wd_d = '0;
    end else if (wd_q != c_wd_max) begin
      wd_d = wd_q + 1'b1;
    end
    // A stale display must not leave half a frame to be mixed with new digits
    if (wd_q == c_wd_max && !w_legal_sample) begin
      captured_d = '0;
    end
`endif

    if (w_sample) begin
      if (!w_onehot || w_illegal) begin
        seg_err_d = 1'b1;
      end else begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (w_sel[i]) begin
            shadow_num_d[i*BITS_PER_DIGIT +: BITS_PER_DIGIT] = w_nibble;
            shadow_dots_d[i] = ~dot_sync_q;
            captured_d[i]    = 1'b1;
          end
        end
        if (&captured_d) begin
          frame_pending_d = 1'b1;
        end
      end
    end
  end

  // Frame assembly and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      captured_q      <= '0;
      shadow_num_q    <= '0;
      shadow_dots_q   <= '0;
      frame_pending_q <= 1'b0;
      num_q           <= '0;
      dots_q          <= '0;
      valid_q         <= 1'b0;
      seg_err_q       <= 1'b0;
    end else begin
      captured_q      <= captured_d;
      shadow_num_q    <= shadow_num_d;
      shadow_dots_q   <= shadow_dots_d;
      frame_pending_q <= frame_pending_d;
      num_q           <= num_d;
      dots_q          <= dots_d;
      valid_q         <= valid_d;
      seg_err_q       <= seg_err_d;
    end
  end

  assign num     = num_q;
  assign dots    = dots_q;
  assign valid   = valid_q;
  assign seg_err = seg_err_q;

endmodule : seven_segment_capture
`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seven_segment_capture
// Description : Self-checking bench for seven_segment_capture. Inputs are
//               driven as dwell periods (anodes/segments/dot held for a
//               number of cycles); a reference model predicts, per cycle,
//               the seg_err and valid pulses and the published frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_capture;

  localparam int W    = 32;
  localparam int ND   = 8;
  localparam int S    = 2;
  localparam int MAXC = 16384;

  localparam logic [6:0] GT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [ND-1:0] anodes = '1;
  logic [6:0]    abcdefg = 7'h7F;
  logic          dot = 1'b1;
  logic [W-1:0]  num;
  logic [ND-1:0] dots;
  logic          valid, seg_err, stale;

  seven_segment_capture #(
    .W(W), .BITS_PER_DIGIT(4), .N_DIGITS(ND), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .reset(reset), .anodes(anodes), .abcdefg(abcdefg), .dot(dot),
    .num(num), .dots(dots), .valid(valid), .seg_err(seg_err), .stale(stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Predicted per-cycle events
  bit            exp_err [MAXC];
  bit            exp_val [MAXC];
  logic [W-1:0]  exp_fnum [MAXC];
  logic [ND-1:0] exp_fdots [MAXC];

  // Reference model state
  bit   [ND-1:0] m_cap = '0;
  logic [W-1:0]  m_shadow = '0;
  logic [ND-1:0] m_sdots = '0;
  logic [ND-1:0] last_an = '1;

  function automatic int glyph_value(input logic [6:0] seg);
    for (int i = 0; i < 16; i++) if (GT[i] == seg) return i;
    return -1;
  endfunction

  // One sample seen by the capture logic at cycle c
  task automatic model_sample(input logic [ND-1:0] an, input logic [6:0] seg,
                              input logic dt, input int c);
    logic [ND-1:0] inv;
    int v, slot;
    if (c + 1 >= MAXC) return;
    inv = ~an;
    v = glyph_value(seg);
    if (inv == '0 || (inv & (inv - 1'b1)) != '0 || v < 0) begin
      exp_err[c] = 1'b1;
    end else begin
      slot = 0;
      for (int i = 0; i < ND; i++) if (inv[i]) slot = i;
      m_shadow[slot*4 +: 4] = 4'(v);
      m_sdots[slot] = ~dt;
      m_cap[slot] = 1'b1;
      if (&m_cap) begin
        exp_val[c+1]   = 1'b1;
        exp_fnum[c+1]  = m_shadow;
        exp_fdots[c+1] = m_sdots;
        m_cap = '0;
      end
    end
  endtask

  // Hold pins for d cycles; a dwell of at least S+1 cycles that differs from
  // the previous one is sampled S+3 edges after it is applied.
  task automatic drive_period(input logic [ND-1:0] an, input logic [6:0] seg,
                              input logic dt, input int d);
    int n;
    n = cyc;
    anodes = an; abcdefg = seg; dot = dt;
    if (d >= S + 1 && an != last_an) model_sample(an, seg, dt, n + 3 + S);
    last_an = an;
    repeat (d) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [W-1:0] value, input logic [ND-1:0] dv,
                      input int blank_slot, input int n_slots);
    logic [6:0] g;
    for (int i = 0; i < n_slots; i++) begin
      g = (i == blank_slot) ? 7'h7F : GT[value[i*4 +: 4]];
      drive_period(~(ND'(1) << i), g, ~dv[i],
                   (i == n_slots - 1) ? S + 5 : int'($urandom_range(S + 1, S + 3)));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    anodes = '1; abcdefg = 7'h7F; dot = 1'b1;
    for (int i = cyc; i < MAXC; i++) begin exp_err[i] = 1'b0; exp_val[i] = 1'b0; end
    m_cap = '0; m_shadow = '0; m_sdots = '0; last_an = '1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_err[cyc + S] = 1'b1;   // idle all-ones anodes are sampled as not one-hot
    repeat (S + 4) @(posedge clk);
    #1;
  endtask

  // Cycle-by-cycle monitor against the model's predictions
  logic [W-1:0]  cur_num  = '0;
  logic [ND-1:0] cur_dots = '0;
  int n_valid = 0;
  int n_err   = 0;
  always @(negedge clk) begin
    if (valid === 1'b1) n_valid++;
    if (seg_err === 1'b1) n_err++;
    if (reset) begin
      cur_num = '0; cur_dots = '0;
    end else if (cyc < MAXC && exp_val[cyc]) begin
      cur_num = exp_fnum[cyc]; cur_dots = exp_fdots[cyc];
    end
    if (cyc < MAXC) begin
      check_value("valid", 64'(valid), 64'(exp_val[cyc]));
      check_value("seg_err", 64'(seg_err), 64'(exp_err[cyc]));
      check_value("num", 64'(num), 64'(cur_num));
      check_value("dots", 64'(dots), 64'(cur_dots));
      check_value("stale", 64'(stale), 64'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, e0;
    logic [ND-1:0] an;
    logic [6:0] seg;
    logic [W-1:0] rn;

    @(posedge clk); #1;
    check_value("reset_num", 64'(num), 64'd0);
    check_value("reset_valid", 64'(valid), 64'd0);
    do_reset();

    // Loopback: two full scans of 1234ABCD with dots 81
    v0 = n_valid; e0 = n_err;
    scan(32'h1234ABCD, 8'h81, -1, ND);
    scan(32'h1234ABCD, 8'h81, -1, ND);
    check_value("loop_num", 64'(num), 64'h1234ABCD);
    check_value("loop_dots", 64'(dots), 64'h81);
    check_value("loop_valid_cnt", 64'(n_valid - v0), 64'd2);
    check_value("loop_err_cnt", 64'(n_err - e0), 64'd0);

    // Slot 3 blank: error on every slot-3 sample, no frame
    v0 = n_valid; e0 = n_err;
    scan(32'h55667788, 8'h0F, 3, ND);
    scan(32'h55667788, 8'h0F, 3, ND);
    check_value("blank_valid_cnt", 64'(n_valid - v0), 64'd0);
    check_value("blank_err_cnt", 64'(n_err - e0), 64'd2);
    check_value("blank_num_kept", 64'(num), 64'h1234ABCD);

    // Anode glitch for one cycle: no sample; held for four: one error
    drive_period(8'hFE, GT[1], 1'b1, S + 5);
    e0 = n_err;
    drive_period(8'hFC, GT[2], 1'b1, 1);
    drive_period(8'hFE, GT[1], 1'b1, S + 5);
    check_value("glitch1_err_cnt", 64'(n_err - e0), 64'd0);
    e0 = n_err;
    drive_period(8'hFC, GT[2], 1'b1, 4);
    drive_period(8'hFD, GT[3], 1'b1, S + 5);
    check_value("glitch4_err_cnt", 64'(n_err - e0), 64'd1);

    // Change on the sampling cycle suppresses that sample
    drive_period(8'hFB, 7'h7F, 1'b1, S);
    e0 = n_err;
    drive_period(8'hF7, GT[9], 1'b1, S + 5);
    check_value("suppress_err_cnt", 64'(n_err - e0), 64'd0);

    // Random loopback frames
    for (int k = 0; k < 4; k++) begin
      rn = $urandom;
      scan(rn, 8'($urandom), -1, ND);
      check_value("rand_frame_num", 64'(num), 64'(rn));
    end

    // Randomised dwell periods
    for (int p = 0; p < 400; p++) begin
      an = ~(ND'(1) << $urandom_range(0, ND - 1));
      if ($urandom_range(0, 19) == 0) an = ND'($urandom);
      if (an == last_an) an[0] = ~an[0];
      seg = ($urandom_range(0, 9) == 0) ? 7'($urandom) : GT[$urandom_range(0, 15)];
      drive_period(an, seg, 1'($urandom), int'($urandom_range(1, S + 4)));
    end
    drive_period(8'h7F, GT[0], 1'b1, S + 5);

    // Reset mid-frame discards the partial frame
    scan(32'h89ABCDEF, 8'h00, -1, 5);
    do_reset();
    v0 = n_valid;
    scan(32'hFFFF0000, 8'h3C, -1, ND - 1);
    check_value("post_reset_no_early_valid", 64'(n_valid - v0), 64'd0);
    scan(32'hFFFF0000, 8'h3C, -1, ND);
    check_value("post_reset_valid_cnt", 64'(n_valid - v0), 64'd1);
    check_value("post_reset_num", 64'(num), 64'hFFFF0000);
    check_value("post_reset_dots", 64'(dots), 64'h3C);

    repeat (8) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seven_segment_capture
`default_nettype wire

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive end of the multiplexed seven-segment display interface.
- Monitors the scanning anodes, abcdefg and dot lines produced by a display driver, either our own driver in loopback or an external board.
- Decodes each digit's segment pattern back to a hex nibble and reassembles the full number and dot vector.
- Used as a self-check monitor on DE10-Lite designs and as a capture front-end for external displays.

Parameters:
w, 32, total width of reconstructed number
bits_per_digit, 4, bits per digit (decoder supports 4 only)
n_digits, w / bits_per_digit, number of scanned digits
settle_cycles, 2, consecutive stable-anode cycles required before sampling segments (>= 1)
timeout_cycles, 65536, watchdog limit (optional feature only)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
anodes  input  n_digits  scanned anodes, active-low one-hot (exactly one 0 = digit selected)
abcdefg  input  7  segments, active-low, bit 6 = a
dot  input  1  decimal point, active-low
num  output  w  last complete captured number; digit i at num[i*bits_per_digit +: bits_per_digit]
dots  output  n_digits  last complete dot vector, active-high
valid  output  1  one-cycle pulse: num/dots updated with a new full frame
seg_err  output  1  one-cycle pulse: sampled pattern not a legal hex glyph, or anodes not one-hot-low
stale  output  1  watchdog flag (optional feature; tied 0 when compiled out)

Behaviour:
- Synchronisation: anodes, abcdefg and dot each pass through a 2-flop synchroniser. Sync flops reset to inactive (all ones).
- Change detect: compare synchronised anodes with a registered previous copy. Any difference is an anode change.
- FSM, states SETTLE and HOLD:
  - SETTLE: settle counter increments while anodes are unchanged. Any anode change clears the counter and remains in SETTLE.
  - When the counter reaches settle_cycles - 1 and anodes are unchanged, sample and go to HOLD.
  - HOLD: wait. An anode change moves to SETTLE with the counter at 0.
- Sample action:
  - If anodes are not one-hot-low, pulse seg_err. No shadow update.
  - Otherwise, with slot i = position of the 0, decode abcdefg:
    - Legal glyph: shadow digit i <= nibble; shadow dot i <= ~dot; captured[i] <= 1.
    - Illegal glyph (includes blank 7'h7F): pulse seg_err; captured[i] unchanged.
- Re-capturing a slot already marked captured overwrites its shadow. The latest sample wins.
- Frame complete: on the sample that makes captured all ones, in the next cycle:
  - num <= shadow, dots <= shadow dots;
  - valid = 1 for one cycle;
  - captured <= 0.
  - The sample's own digit is included in the frame.
- Glyph table, active-low abcdefg:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- Simultaneous events: an anode change in the cycle the counter would sample suppresses the sample; the change wins.
- Latency:
  - Pin anode edge to sample: 2 sync cycles plus settle_cycles.
  - Last sample to valid/num update: 1 cycle.
- Reset values:
  - num = 0, dots = 0, valid = 0, seg_err = 0, stale = 0.
  - captured = 0, shadow = 0, state SETTLE, counter 0.
- Reset asserted mid-frame discards the partial frame.

Optional Feature:
- Macro: SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on every legal sample and saturates at timeout_cycles.
  - stale = 1 while saturated; it clears on the next legal sample.
  - On saturation, captured is cleared so no frame mixes old and new digits.
- Undefined: no counter; stale tied to 0.

Decomposition:
- Shared package/header:
  - the 16 active-low glyph constants (shared with the driver's digit encoder);
  - the blank constant 7'h7F;
  - the FSM state encodings.
- One combinational sub-module, seven_segment_glyph_decode: abcdefg in; hex nibble and illegal flag out.

Test Plan:
- Loopback from the display driver, num = 32'h1234ABCD, dots = 8'h81, settle_cycles = 2 -> after ≤ 2 full scans valid pulses; num = 32'h1234ABCD, dots = 8'h81; seg_err never asserted.
- Slot 3 shows 7'h7F (blank) while other slots are legal -> seg_err pulses on each slot-3 sample; valid is never asserted; num stays at its previous value.
- Anodes glitch 8'b11111100 for 1 cycle -> no sample (settle not met); no seg_err. Hold the same value for 4 cycles -> one seg_err pulse.
- Anode change arrives exactly on the sampling cycle -> no sample that cycle; sample taken settle_cycles later with the new slot.
- Reset asserted after 5 of 8 digits are captured, then a full scan of 32'hFFFF0000 -> valid only after all 8 slots are captured post-reset; num = 32'hFFFF0000.
- With SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN and timeout_cycles = 100, freeze the anodes -> stale = 1 at cycle 100 after the last sample; it clears on the next legal sample.
